// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: double-buffered digit data,
// per-digit enable, PWM brightness and registered active-low drive.
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int PWM_BITS    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       digits,
    input  logic [NUM_DIGITS-1:0]         dp,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic [PWM_BITS-1:0]           brightness,
    output logic [NUM_DIGITS-1:0]         anode,
    output logic [6:0]                    cathode,
    output logic                          dp_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
    logic [PWM_BITS-1:0]     pwm_cnt_q, pwm_cnt_d;
    logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
    logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;
    logic                    frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [6:0]              cathode_q, cathode_d;
    logic                    dp_n_q, dp_n_d;

    logic       div_end;
    logic       wrap;
    logic       lit;
    logic       drive;
    logic [3:0] cur_nib;

    // Active-low {g,f,e,d,c,b,a} hex font.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    always_comb begin
        div_end = (div_cnt_q == DIV_LAST);
        wrap    = en && div_end && (digit_idx_q == IDX_LAST);

        div_cnt_d     = div_cnt_q;
        digit_idx_d   = digit_idx_q;
        pwm_cnt_d     = pwm_cnt_q;
        pend_digits_d = pend_digits_q;
        pend_dp_d     = pend_dp_q;
        pend_en_d     = pend_en_q;
        act_digits_d  = act_digits_q;
        act_dp_d      = act_dp_q;
        act_en_d      = act_en_q;

        if (en) begin
            pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
            if (div_end) begin
                div_cnt_d   = '0;
                digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + IDX_W'(1);
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end

        if (load) begin
            pend_digits_d = digits;
            pend_dp_d     = dp;
            pend_en_d     = digit_en;
        end

        // Taking the post-load pending value lets a load on the wrap edge go live at once.
        if (wrap) begin
            act_digits_d = pend_digits_d;
            act_dp_d     = pend_dp_d;
            act_en_d     = pend_en_d;
        end

        frame_done_d = wrap;

        lit     = (&brightness) || (pwm_cnt_q < brightness);
        cur_nib = act_digits_q[{digit_idx_q, 2'b00} +: 4];
        drive   = en && lit && act_en_q[digit_idx_q];

        anode_d   = '1;
        cathode_d = '1;
        dp_n_d    = 1'b1;
        if (drive) begin
            anode_d[digit_idx_q] = 1'b0;
            cathode_d            = hex_to_seg(cur_nib);
            dp_n_d               = ~act_dp_q[digit_idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q     <= '0;
            digit_idx_q   <= '0;
            pwm_cnt_q     <= '0;
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_en_q     <= '0;
            act_digits_q  <= '0;
            act_dp_q      <= '0;
            act_en_q      <= '0;
            frame_done_q  <= 1'b0;
            anode_q       <= '1;
            cathode_q     <= '1;
            dp_n_q        <= 1'b1;
        end else begin
            div_cnt_q     <= div_cnt_d;
            digit_idx_q   <= digit_idx_d;
            pwm_cnt_q     <= pwm_cnt_d;
            pend_digits_q <= pend_digits_d;
            pend_dp_q     <= pend_dp_d;
            pend_en_q     <= pend_en_d;
            act_digits_q  <= act_digits_d;
            act_dp_q      <= act_dp_d;
            act_en_q      <= act_en_d;
            frame_done_q  <= frame_done_d;
            anode_q       <= anode_d;
            cathode_q     <= cathode_d;
            dp_n_q        <= dp_n_d;
        end
    end

    assign anode      = anode_q;
    assign cathode    = cathode_q;
    assign dp_n       = dp_n_q;
    assign digit_idx  = digit_idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with 4 digits, 4-cycle slots, 2-bit PWM.
module tb_sevenseg_scan_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        load;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic [1:0]  brightness;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        dp_n;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-written font values for digits 0,1,2,3 of 16'h3210.
    logic [6:0] exp_seg [4] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000};

    sevenseg_scan_ctrl #(
        .NUM_DIGITS (4),
        .REFRESH_DIV(4),
        .PWM_BITS   (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .load      (load),
        .digits    (digits),
        .dp        (dp),
        .digit_en  (digit_en),
        .brightness(brightness),
        .anode     (anode),
        .cathode   (cathode),
        .dp_n      (dp_n),
        .digit_idx (digit_idx),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] sel(input int d);
        logic [3:0] a;
        a    = 4'hF;
        a[d] = 1'b0;
        return a;
    endfunction

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            step();
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] de, input logic [3:0] p);
        digits = d; digit_en = de; dp = p; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; load = 1'b1;
        digits = 16'h8888; digit_en = 4'hF; dp = 4'hF; brightness = 2'd3;
        repeat (3) step();
        n_checks++;
        if (anode !== 4'hF) begin n_fail++; $display("FAIL rst_anode got %b want 1111", anode); end
        n_checks++;
        if (cathode !== 7'h7F) begin n_fail++; $display("FAIL rst_cathode got %b want 1111111", cathode); end
        n_checks++;
        if (dp_n !== 1'b1) begin n_fail++; $display("FAIL rst_dp_n got %b want 1", dp_n); end
        n_checks++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
        n_checks++;
        if (digit_idx !== 2'd0) begin n_fail++; $display("FAIL rst_digit_idx got %0d want 0", digit_idx); end
        reset = 1'b0; load = 1'b0;
        for (int j = 1; j <= 17; j++) begin
            step();
            n_checks++;
            if (anode !== 4'hF) begin n_fail++; $display("FAIL rst_blank j=%0d got %b want 1111", j, anode); end
            n_checks++;
            if (frame_done !== (j == 16)) begin
                n_fail++; $display("FAIL rst_first_frame j=%0d got %b want %b", j, frame_done, (j == 16));
            end
        end
    endtask

    task automatic test_basic();
        bit ok;
        brightness = 2'd3;
        do_load(16'h3210, 4'hF, 4'h0);
        wait_frame(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_sync got timeout want frame_done"); end
        for (int j = 1; j <= 16; j++) begin
            step();
            n_checks++;
            if (anode !== sel((j - 1) / 4)) begin
                n_fail++; $display("FAIL basic_anode j=%0d got %b want %b", j, anode, sel((j - 1) / 4));
            end
            n_checks++;
            if (cathode !== exp_seg[(j - 1) / 4]) begin
                n_fail++; $display("FAIL basic_cathode j=%0d got %b want %b", j, cathode, exp_seg[(j - 1) / 4]);
            end
            n_checks++;
            if (digit_idx !== 2'((j / 4) % 4)) begin
                n_fail++; $display("FAIL basic_idx j=%0d got %0d want %0d", j, digit_idx, (j / 4) % 4);
            end
            n_checks++;
            if (dp_n !== 1'b1) begin n_fail++; $display("FAIL basic_dp_n j=%0d got %b want 1", j, dp_n); end
            n_checks++;
            if (frame_done !== (j == 16)) begin
                n_fail++; $display("FAIL basic_frame_done j=%0d got %b want %b", j, frame_done, (j == 16));
            end
        end
    endtask

    task automatic test_pwm();
        bit ok;
        int lit;
        logic [1:0] br_tab [3] = '{2'd1, 2'd0, 2'd2};
        int         lit_tab[3] = '{4, 0, 8};
        wait_frame(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL pwm_sync got timeout want frame_done"); end
        for (int t = 0; t < 3; t++) begin
            brightness = br_tab[t];
            lit = 0;
            for (int j = 1; j <= 16; j++) begin
                step();
                if (anode !== 4'hF) begin
                    lit++;
                    n_checks++;
                    if (anode !== sel((j - 1) / 4)) begin
                        n_fail++; $display("FAIL pwm_anode br=%0d j=%0d got %b want %b", br_tab[t], j, anode, sel((j - 1) / 4));
                    end
                end
            end
            n_checks++;
            if (lit != lit_tab[t]) begin
                n_fail++; $display("FAIL pwm_duty br=%0d got %0d lit want %0d", br_tab[t], lit, lit_tab[t]);
            end
        end
        brightness = 2'd3;
    endtask

    task automatic test_double_buffer();
        bit ok;
        wait_frame(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL dbuf_sync got timeout want frame_done"); end
        for (int j = 1; j <= 32; j++) begin
            load = 1'b0;
            if (j == 3) begin digits = 16'hFFFF; load = 1'b1; end
            if (j == 9) begin digits = 16'hAAAA; load = 1'b1; end
            step();
            load = 1'b0;
            n_checks++;
            if (j <= 16) begin
                if (cathode !== exp_seg[(j - 1) / 4]) begin
                    n_fail++; $display("FAIL dbuf_old j=%0d got %b want %b", j, cathode, exp_seg[(j - 1) / 4]);
                end
            end else begin
                if (cathode !== 7'b0001000) begin
                    n_fail++; $display("FAIL dbuf_new j=%0d got %b want 0001000", j, cathode);
                end
            end
            n_checks++;
            if (anode !== sel(((j - 1) / 4) % 4)) begin
                n_fail++; $display("FAIL dbuf_anode j=%0d got %b want %b", j, anode, sel(((j - 1) / 4) % 4));
            end
        end
    endtask

    task automatic test_load_on_wrap();
        bit ok;
        wait_frame(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL lwrap_sync got timeout want frame_done"); end
        repeat (15) step();
        digits = 16'h8888; load = 1'b1;
        step();
        load = 1'b0;
        n_checks++;
        if (frame_done !== 1'b1) begin n_fail++; $display("FAIL lwrap_frame_done got %b want 1", frame_done); end
        n_checks++;
        if (cathode !== 7'b0001000) begin n_fail++; $display("FAIL lwrap_before got %b want 0001000", cathode); end
        step();
        n_checks++;
        if (anode !== 4'b1110) begin n_fail++; $display("FAIL lwrap_anode got %b want 1110", anode); end
        n_checks++;
        if (cathode !== 7'b0000000) begin n_fail++; $display("FAIL lwrap_after got %b want 0000000", cathode); end
    endtask

    task automatic test_digit_en();
        bit ok;
        logic [3:0] exp_a;
        logic [6:0] exp_c;
        wait_frame(ok);
        do_load(16'h3210, 4'b0101, 4'b0001);
        wait_frame(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL den_sync got timeout want frame_done"); end
        for (int j = 1; j <= 16; j++) begin
            step();
            exp_a = (((j - 1) / 4) % 2 == 0) ? sel((j - 1) / 4) : 4'hF;
            exp_c = (((j - 1) / 4) % 2 == 0) ? exp_seg[(j - 1) / 4] : 7'h7F;
            n_checks++;
            if (anode !== exp_a) begin n_fail++; $display("FAIL den_anode j=%0d got %b want %b", j, anode, exp_a); end
            n_checks++;
            if (cathode !== exp_c) begin n_fail++; $display("FAIL den_cathode j=%0d got %b want %b", j, cathode, exp_c); end
            n_checks++;
            if (dp_n !== (j > 4)) begin n_fail++; $display("FAIL den_dp_n j=%0d got %b want %b", j, dp_n, (j > 4)); end
        end
    endtask

    task automatic test_freeze();
        bit ok;
        logic [3:0] a_tab [4] = '{4'b1101, 4'b1101, 4'b1101, 4'b1011};
        logic [1:0] i_tab [4] = '{2'd1, 2'd1, 2'd2, 2'd2};
        do_load(16'h3210, 4'hF, 4'h0);
        wait_frame(ok);
        wait_frame(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL frz_sync got timeout want frame_done"); end
        repeat (5) step();
        n_checks++;
        if (anode !== 4'b1101) begin n_fail++; $display("FAIL frz_pre got %b want 1101", anode); end
        en = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            step();
            n_checks++;
            if (anode !== 4'hF || cathode !== 7'h7F || dp_n !== 1'b1) begin
                n_fail++; $display("FAIL frz_blank j=%0d got %b/%b/%b want 1111/1111111/1", j, anode, cathode, dp_n);
            end
            n_checks++;
            if (digit_idx !== 2'd1) begin n_fail++; $display("FAIL frz_idx j=%0d got %0d want 1", j, digit_idx); end
            n_checks++;
            if (frame_done !== 1'b0) begin n_fail++; $display("FAIL frz_frame j=%0d got %b want 0", j, frame_done); end
        end
        en = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            n_checks++;
            if (anode !== a_tab[j]) begin n_fail++; $display("FAIL frz_resume_anode j=%0d got %b want %b", j, anode, a_tab[j]); end
            n_checks++;
            if (digit_idx !== i_tab[j]) begin n_fail++; $display("FAIL frz_resume_idx j=%0d got %0d want %0d", j, digit_idx, i_tab[j]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_frame(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rmid_sync got timeout want frame_done"); end
        repeat (8) step();
        do_load(16'h8888, 4'hF, 4'h0);
        n_checks++;
        if (digit_idx !== 2'd2) begin n_fail++; $display("FAIL rmid_pre_idx got %0d want 2", digit_idx); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (anode !== 4'hF || cathode !== 7'h7F) begin
            n_fail++; $display("FAIL rmid_blank got %b/%b want 1111/1111111", anode, cathode);
        end
        n_checks++;
        if (digit_idx !== 2'd0) begin n_fail++; $display("FAIL rmid_idx got %0d want 0", digit_idx); end
        n_checks++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rmid_frame got %b want 0", frame_done); end
        for (int j = 1; j <= 20; j++) begin
            step();
            n_checks++;
            if (anode !== 4'hF) begin n_fail++; $display("FAIL rmid_stay_blank j=%0d got %b want 1111", j, anode); end
            n_checks++;
            if (frame_done !== (j == 16)) begin
                n_fail++; $display("FAIL rmid_frame_seq j=%0d got %b want %b", j, frame_done, (j == 16));
            end
        end
        do_load(16'h0000, 4'hF, 4'h0);
        wait_frame(ok);
        step();
        n_checks++;
        if (anode !== 4'b1110 || cathode !== 7'b1000000) begin
            n_fail++; $display("FAIL rmid_reload got %b/%b want 1110/1000000", anode, cathode);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pwm();
        test_double_buffer();
        test_load_on_wrap();
        test_digit_en();
        test_freeze();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sevenseg_scan_ctrl.md
SEVENSEG_SCAN_CTRL -- requirements
Module: sevenseg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of multiplexed digits, legal range 2..8.
REQ-002 Parameter REFRESH_DIV, default 100000, clock cycles each digit is selected, legal range >= 2.
REQ-003 Parameter PWM_BITS, default 4, width of the brightness control, legal range 1..8.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  scan enable; 0 freezes counters and blanks the display.
REQ-007 load  input  1  single-cycle strobe capturing digits/dp/digit_en into the pending buffer.
REQ-008 digits  input  4*NUM_DIGITS  hex nibble per digit, digit i at bits [4i+3:4i].
REQ-009 dp  input  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-010 digit_en  input  NUM_DIGITS  per-digit enable, 0 = digit blanked.
REQ-011 brightness  input  PWM_BITS  duty control, sampled every cycle.
REQ-012 anode  output  NUM_DIGITS  active-low digit select, at most one bit low.
REQ-013 cathode  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-014 dp_n  output  1  active-low decimal point.
REQ-015 digit_idx  output  $clog2(NUM_DIGITS)  index of currently scanned digit.
REQ-016 frame_done  output  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0.

Function
REQ-017 Divider div_cnt SHALL count 0..REFRESH_DIV-1 while en=1; at REFRESH_DIV-1 it SHALL wrap to 0 and advance digit_idx by one.
REQ-018 digit_idx SHALL wrap NUM_DIGITS-1 -> 0; frame_done SHALL be 1 in exactly the cycle following that wrap edge, else 0.
REQ-019 Double buffering: load=1 SHALL overwrite the pending buffer; pending SHALL copy to the active buffer on each digit_idx wrap to 0; the display SHALL use only the active buffer.
REQ-020 Multiple loads within one frame: last one wins; load coincident with wrap SHALL pass the new inputs straight into the active buffer that same edge.
REQ-021 PWM counter pwm_cnt (PWM_BITS wide) SHALL free-run while en=1, wrapping at all-ones; lit = (brightness == all-ones) or (pwm_cnt < brightness); brightness 0 SHALL never light.
REQ-022 anode[digit_idx] SHALL be 0 only when en=1, lit=1 and active digit_en[digit_idx]=1; all other anode bits SHALL be 1.
REQ-023 cathode SHALL hex-decode active nibble: 0->1000000, 1->1111001, 8->0000000, A->0001000, F->0001110, remaining per standard a-g font; all-ones when the anode is not driven.
REQ-024 dp_n SHALL be ~dp[digit_idx] from the active buffer when the anode is driven, else 1.
REQ-025 anode, cathode, dp_n SHALL be registered, reflecting digit_idx/pwm_cnt state with one cycle latency.
REQ-026 en=0: div_cnt, pwm_cnt, digit_idx hold; pending buffer still accepts load; outputs blank (anode, cathode, dp_n all ones) from next cycle; en=1 resumes from held state.

Reset
REQ-027 reset=1 SHALL clear div_cnt, pwm_cnt, digit_idx, pending and active buffers to 0, overriding en and load.
REQ-028 During and the cycle after reset: anode all ones, cathode 7'b1111111, dp_n 1, frame_done 0, digit_idx 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no frame_done pulse and discard any pending load.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, PWM_BITS=2)
REQ-030 Reset then en=1, brightness=3, load digits=16'h3210, digit_en=4'hF -> after first frame_done, anode cycles 1110,1101,1011,0111 each 4 cycles, cathode 1000000,1111001,0100100,0110000.
REQ-031 brightness=1 -> selected anode low 1 cycle in every 4; brightness=0 -> anode stays 4'b1111.
REQ-032 Load 16'hFFFF mid-frame then 16'hAAAA before wrap -> display unchanged until wrap, then all digits show 0001000; 16'hFFFF never displayed.
REQ-033 digit_en=4'b0101, dp=4'b0001 -> digits 1,3 never selected; dp_n=0 only while anode=1110.
REQ-034 en=0 for 10 cycles mid-slot -> outputs blank, digit_idx constant; en=1 -> slot resumes with remaining div_cnt count.
REQ-035 reset during digit 2 -> next cycle anode=1111, digit_idx=0, no frame_done, display blank until a new load and frame wrap.
